ser_rx4b: RTL

- Serial receiver for the 4-bit shift-register serial link. It consumes the bit stream driven on the register's s_out and rebuilds parallel words.
- Frames each word as start bit, data bits, optional even-parity bit and stop bit. It checks parity and framing, then presents the word on q with a valid/ack handshake.
- Sits at the far end of the serial path, as the counterpart of the parallel-load / shift-out register.

---
 rtl/ser_rx4b_pkg.sv | 19 +
 rtl/ser_rx4b_rx_hold_buf.sv | 44 ++++
 rtl/ser_rx4b.sv | 113 +++++++++++
 3 files changed

// File: rtl/ser_rx4b_pkg.sv
// Shared framing definitions for the 4-bit serial link (receiver and framer side).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ser_rx4b_pkg;

  // Receiver framing FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } rx_state_e;

  // Line levels of the frame delimiters; the line rests low between frames
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/ser_rx4b_rx_hold_buf.sv
// Holding register for received words: q/valid with ack handshake and overrun flag.
// Latency: a completed word appears on q/valid one clk after word_vld_i.
// Backpressure: none; a new word overwrites an unacked one and pulses ovr_o.
module rx_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             word_vld_i,
  input  logic [WIDTH-1:0] word_dat_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             ovr_o
);

  logic [WIDTH-1:0] q_q;
  logic             valid_q;
  logic             ovr_q;

  // Load new words, retire acked words, flag words lost to overwrite
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (word_vld_i) begin
        q_q     <= word_dat_i;
        valid_q <= 1'b1;
        // Same-cycle ack consumes the old word, so nothing is lost
        ovr_q   <= valid_q && !ack_i;
      end else if (valid_q && ack_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/ser_rx4b.sv
// Serial receiver: start / WIDTH data / optional even parity / stop, checked and held on q.
// Latency: q/valid update one clk after the stop-bit strobe edge; error pulses likewise.
// Backpressure: none; the line is never stalled, unacked words are overwritten (ovr).
module ser_rx4b
  import ser_rx4b_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             err_par,
  output logic             err_frm,
  output logic             ovr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             dir_q, dir_d;
  logic             par_q, par_d;
  logic             err_par_q, err_frm_q;
  logic             good_w, perr_w, ferr_w;

  // Framing FSM state and datapath registers; error flags are registered pulses
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      dir_q     <= 1'b0;
      par_q     <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      dir_q     <= dir_d;
      par_q     <= par_d;
      err_par_q <= perr_w;
      err_frm_q <= ferr_w;
    end
  end

  // Next-state and frame evaluation; everything holds on cycles without a strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    par_d   = par_q;
    good_w  = 1'b0;
    perr_w  = 1'b0;
    ferr_w  = 1'b0;
    if (enb) begin
      case (state_q)
        ST_IDLE: begin
          if (s_in == START_BIT) begin
            dir_d   = dir;
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          sr_d  = dir_q ? {s_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], s_in};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
          end
        end
        ST_PAR: begin
          par_d   = s_in;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          // A bad stop bit outranks a parity mismatch
          if (s_in != STOP_BIT) begin
            ferr_w = 1'b1;
          end else if ((PARITY_EN != 0) && ((^sr_q) ^ par_q)) begin
            perr_w = 1'b1;
          end else begin
            good_w = 1'b1;
          end
        end
      endcase
    end
  end

  rx_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .reset_L    (reset_L),
    .word_vld_i (good_w),
    .word_dat_i (sr_q),
    .ack_i      (ack),
    .q_o        (q),
    .valid_o    (valid),
    .ovr_o      (ovr)
  );

  assign err_par = err_par_q;
  assign err_frm = err_frm_q;

endmodule
